// File: rtl/decode_inst_queue.sv
// decode_inst_queue
// First-word-fall-through queue for decoded instruction packets. It sits
// between the decode mux and dispatch. Decode cannot stop instantly, so a
// registered high-water stall warns it early while in-flight packets still
// fit. A flush discards all queued contents.
module decode_inst_queue #(
  parameter int depth       = 8,
  parameter int skid        = 3,
  parameter int packetWidth = 308,
  parameter int countWidth  = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [packetWidth-1:0] packet_i,
  input  logic                   flush_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [packetWidth-1:0] packet_o,
  output logic                   stall_o,
  output logic [countWidth-1:0]  count_o,
  output logic                   overflow_o
);

  localparam int ptrWidth = $clog2(depth);
  localparam logic [countWidth-1:0] full_count  = countWidth'(depth);
  localparam logic [countWidth-1:0] stall_count = countWidth'(depth - skid);

  logic [packetWidth-1:0] mem_reg [depth];
  logic [ptrWidth-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [ptrWidth-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [countWidth-1:0]  count_reg, count_next;
  logic                   stall_reg, stall_next;
  logic                   overflow_reg, overflow_next;
  logic                   pop, push, wr_en;

  // Handshake decode: a full queue still accepts a push when the head leaves
  // in the same cycle; a flush cancels both the push and the pop.
  always_comb begin
    pop   = (count_reg != '0) & ready_i;
    push  = enable_i & ((count_reg < full_count) | pop);
    wr_en = push & ~flush_i;
  end

  // Next-state for pointers, occupancy and flags; flush overrides everything.
  always_comb begin
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (flush_i) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (pop)
        rd_ptr_next = rd_ptr_reg + ptrWidth'(1);
      if (push)
        wr_ptr_next = wr_ptr_reg + ptrWidth'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + countWidth'(1);
        2'b01:   count_next = count_reg - countWidth'(1);
        default: count_next = count_reg;
      endcase
      // A packet offered to a full queue with no pop is lost; remember it.
      if (enable_i && !push)
        overflow_next = 1'b1;
    end
    stall_next = (count_next >= stall_count);
  end

  // Control state register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      stall_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      stall_reg    <= stall_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage entries; each clears on reset and loads when it is the write slot.
  generate
    for (genvar gi = 0; gi < depth; gi++) begin : g_entry
      always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i)
          mem_reg[gi] <= '0;
        else if (wr_en && (wr_ptr_reg == ptrWidth'(gi)))
          mem_reg[gi] <= packet_i;
      end
    end
  endgenerate

  // Outputs: head entry falls through combinationally from storage.
  always_comb begin
    valid_o    = (count_reg != '0);
    packet_o   = mem_reg[rd_ptr_reg];
    stall_o    = stall_reg;
    count_o    = count_reg;
    overflow_o = overflow_reg;
  end

endmodule

// File: tb/tb_decode_inst_queue.sv
// Testbench for decode_inst_queue: directed steps plus a randomized phase,
// every cycle compared against a queue-based reference model.
module tb_decode_inst_queue;
  localparam int DEPTH = 8;
  localparam int SKID  = 3;
  localparam int PW    = 308;
  localparam int CW    = 4;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          enable_i;
  logic [PW-1:0] packet_i;
  logic          flush_i;
  logic          ready_i;
  logic          valid_o;
  logic [PW-1:0] packet_o;
  logic          stall_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  decode_inst_queue #(
    .depth(DEPTH), .skid(SKID), .packetWidth(PW), .countWidth(CW)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
    .packet_i(packet_i), .flush_i(flush_i), .ready_i(ready_i),
    .valid_o(valid_o), .packet_o(packet_o), .stall_o(stall_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clock_i = ~clock_i;

  // Reference model state
  logic [PW-1:0] mq[$];
  bit            m_stall;
  bit            m_ovf;

  int errors = 0;
  int checks = 0;

  // Output recording for the ordering test
  bit          rec = 0;
  logic [63:0] got[$];

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mkpkt(input logic [63:0] majid);
    logic [PW-1:0] p;
    for (int i = 0; i < PW; i += 32) begin
      logic [31:0] r;
      r = $urandom;
      for (int b = 0; b < 32; b++)
        if (i + b < PW) p[i+b] = r[b];
    end
    p[203:140] = majid;  // majID field: 104 bits below the MSB
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stall = 0;
    m_ovf   = 0;
  endtask

  task automatic model_step(input bit en, input logic [PW-1:0] pkt, input bit rdy, input bit fl);
    bit pop, push;
    pop  = (mq.size() != 0) && rdy;
    push = en && ((mq.size() < DEPTH) || pop);
    if (fl) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(pkt);
      if (en && !push) m_ovf = 1;
      m_stall = (mq.size() >= DEPTH - SKID);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, valid_o, mq.size() != 0);
    chk({tag, ".count"}, count_o, mq.size());
    chk({tag, ".stall"}, stall_o, m_stall);
    chk({tag, ".overflow"}, overflow_o, m_ovf);
    if (mq.size() != 0)
      chk({tag, ".packet"}, packet_o, mq[0]);
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare after.
  task automatic cycle(input string tag, input bit en, input logic [PW-1:0] pkt,
                       input bit rdy, input bit fl);
    enable_i = en;
    packet_i = pkt;
    ready_i  = rdy;
    flush_i  = fl;
    #1;
    if (rec && valid_o && ready_i && !flush_i)
      got.push_back(packet_o[203:140]);
    @(posedge clock_i);
    model_step(en, pkt, rdy, fl);
    #1;
    check_all(tag);
    $display("%0t %s en=%0b rdy=%0b fl=%0b count=%0d valid=%0b stall=%0b ovf=%0b",
             $time, tag, en, rdy, fl, count_o, valid_o, stall_o, overflow_o);
  endtask

  initial begin
    int sent;
    int cyc;
    reset_i = 1'b0; enable_i = 0; packet_i = '0; flush_i = 0; ready_i = 0;
    model_reset();

    // Reset held for three cycles
    repeat (3) @(posedge clock_i);
    #1;
    check_all("reset");
    chk("reset.packet_zero", packet_o, '0);
    reset_i = 1'b1;

    // Single packet: visible next cycle, then consumed
    cycle("single_push", 1, mkpkt(64'd5), 0, 0);
    chk("single.majid", packet_o[203:140], 64'd5);
    cycle("single_pop", 0, '0, 1, 0);

    // Fill to the stall threshold, then to full
    for (int i = 1; i <= 5; i++) cycle("fill", 1, mkpkt(64'(i)), 0, 0);
    chk("fill.stall_after5", stall_o, 1'b1);
    for (int i = 6; i <= 8; i++) cycle("fill", 1, mkpkt(64'(i)), 0, 0);
    chk("fill.count8", count_o, 4'd8);
    chk("fill.no_ovf", overflow_o, 1'b0);

    // Full with push and pop together, then a dropped push
    cycle("full_pushpop", 1, mkpkt(64'd9), 1, 0);
    chk("full_pushpop.count", count_o, 4'd8);
    chk("full_pushpop.head", packet_o[203:140], 64'd2);
    chk("full_pushpop.no_ovf", overflow_o, 1'b0);
    cycle("full_drop", 1, mkpkt(64'd10), 0, 0);
    chk("full_drop.ovf", overflow_o, 1'b1);
    chk("full_drop.count", count_o, 4'd8);

    // Flush priority with count 4
    cycle("flush_empty", 0, '0, 0, 1);
    for (int i = 0; i < 4; i++) cycle("flush_fill", 1, mkpkt(64'(50 + i)), 0, 0);
    chk("flush.count4", count_o, 4'd4);
    cycle("flush", 1, mkpkt(64'd99), 1, 1);
    chk("flush.count0", count_o, 4'd0);
    chk("flush.valid0", valid_o, 1'b0);
    chk("flush.stall0", stall_o, 1'b0);
    for (int i = 0; i < 3; i++) cycle("post_flush", 0, '0, 1, 0);

    // Ordered stream 100..119 with ready toggling; upstream honours stall
    rec = 1;
    sent = 0;
    cyc = 0;
    while (got.size() < 20 && cyc < 200) begin
      bit en;
      en = (sent < 20) && !m_stall;
      cycle("stream", en, mkpkt(64'(100 + sent)), cyc[0], 0);
      if (en) sent++;
      cyc++;
    end
    rec = 0;
    chk("stream.count_out", got.size(), 20);
    for (int i = 0; i < got.size() && i < 20; i++)
      chk($sformatf("stream.order%0d", i), got[i], 64'(100 + i));

    // Randomized traffic including occasional flushes and overflow attempts
    for (int i = 0; i < 300; i++)
      cycle("random", ($urandom % 4) != 0, mkpkt(64'($urandom)), $urandom % 2,
            ($urandom % 32) == 0);

    // Asynchronous reset between edges with six entries queued
    cycle("pre_areset_flush", 0, '0, 0, 1);
    for (int i = 0; i < 6; i++) cycle("areset_fill", 1, mkpkt(64'(200 + i)), 0, 0);
    chk("areset.count6", count_o, 4'd6);
    #2 reset_i = 1'b0;
    #1;
    model_reset();
    check_all("areset_immediate");
    chk("areset.packet_zero", packet_o, '0);
    #2 reset_i = 1'b1;

    // Operation resumes after release
    cycle("resume_push", 1, mkpkt(64'd300), 0, 0);
    chk("resume.majid", packet_o[203:140], 64'd300);
    cycle("resume_pop", 0, '0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
